// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Round-robin arbiter sharing the register-file write port
//                between NREQ writeback requesters, with a registered write
//                stage and a per-register busy scoreboard for RAW stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
   parameter int NREQ  = 3,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int NREGS = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NREQ-1:0]      i_req_vld,
   output logic [NREQ-1:0]      o_req_rdy,
   input  logic [NREQ*AW-1:0]   i_req_addr,
   input  logic [NREQ*DW-1:0]   i_req_data,
   output logic [AW-1:0]        o_reg_waddr,
   output logic [DW-1:0]        o_reg_wdata,
   output logic                 o_reg_wena,
   input  logic                 i_issue_vld,
   input  logic [AW-1:0]        i_issue_addr,
   input  logic                 i_flush,
   output logic [NREGS-1:0]     o_busy
);

   // Pointer width; one extra bit is used while wrapping the scan index.
   localparam int c_PTR_W = $clog2(NREQ);

   logic [c_PTR_W-1:0] r_ptr;
   logic [c_PTR_W:0]   w_scan;
   logic               w_gnt_found;
   logic               w_gnt_vld;
   logic [c_PTR_W-1:0] w_gnt_idx;
   logic [NREQ-1:0]    w_gnt_oh;
   logic [AW-1:0]      w_sel_addr;
   logic [DW-1:0]      w_sel_data;

   logic [AW-1:0]      r_waddr;
   logic [DW-1:0]      r_wdata;
   logic               r_wena;

   logic [NREGS-1:0]   r_busy;
   logic [NREGS-1:0]   w_set;
   logic [NREGS-1:0]   w_clr;

   // Scan requesters starting at the pointer, wrapping modulo NREQ; first valid wins.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_scan      = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_scan = {1'b0, r_ptr} + (c_PTR_W+1)'(i);
         if (w_scan >= (c_PTR_W+1)'(NREQ)) begin
            w_scan = w_scan - (c_PTR_W+1)'(NREQ);
         end
         if (!w_gnt_found && i_req_vld[w_scan[c_PTR_W-1:0]]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_scan[c_PTR_W-1:0];
         end
      end
   end

   // Reset masks the grant so nothing transfers while the block is held in reset.
   assign w_gnt_vld = w_gnt_found & ~i_rst;
   assign w_gnt_oh  = NREQ'(1) << w_gnt_idx;
   assign o_req_rdy = w_gnt_vld ? w_gnt_oh : '0;

   // Select the winning requester's destination and data.
   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt_idx == c_PTR_W'(k)) begin
            w_sel_addr = i_req_addr[k*AW +: AW];
            w_sel_data = i_req_data[k*DW +: DW];
         end
      end
   end

   // Advance the round-robin pointer past the winner; hold when idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (w_gnt_vld) begin
         if (w_gnt_idx == c_PTR_W'(NREQ-1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_gnt_idx + c_PTR_W'(1);
         end
      end
   end

   // Register the accepted write; writes to x0 are accepted but not enabled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_waddr <= '0;
         r_wdata <= '0;
         r_wena  <= 1'b0;
      end else if (w_gnt_vld) begin
         r_waddr <= w_sel_addr;
         r_wdata <= w_sel_data;
         r_wena  <= (w_sel_addr != '0);
      end else begin
         r_wena  <= 1'b0;
      end
   end

   assign o_reg_waddr = r_waddr;
   assign o_reg_wdata = r_wdata;
   assign o_reg_wena  = r_wena;

   // Per-register set/clear terms; register 0 never becomes busy.
   for (genvar r = 0; r < NREGS; r++) begin : g_sb_bit
      if (r == 0) begin : g_zero
         assign w_set[r] = 1'b0;
         assign w_clr[r] = 1'b0;
      end else begin : g_reg
         assign w_set[r] = i_issue_vld && (i_issue_addr == AW'(r));
         assign w_clr[r] = w_gnt_vld && (w_sel_addr == AW'(r));
      end
   end

   // Scoreboard update: flush clears all, a new issue beats a retiring write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= '0;
      end else if (i_flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: directed scenarios then
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
   localparam int NREQ  = 3;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NREGS = 32;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_vld;
   logic [NREQ-1:0]     req_rdy;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_data;
   logic [AW-1:0]       reg_waddr;
   logic [DW-1:0]       reg_wdata;
   logic                reg_wena;
   logic                issue_vld;
   logic [AW-1:0]       issue_addr;
   logic                flush;
   logic [NREGS-1:0]    busy;

   wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_vld    (req_vld),
      .o_req_rdy    (req_rdy),
      .i_req_addr   (req_addr),
      .i_req_data   (req_data),
      .o_reg_waddr  (reg_waddr),
      .o_reg_wdata  (reg_wdata),
      .o_reg_wena   (reg_wena),
      .i_issue_vld  (issue_vld),
      .i_issue_addr (issue_addr),
      .i_flush      (flush),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // requester-side stimulus
   logic [NREQ-1:0] rq_vld;
   logic [AW-1:0]   rq_addr [NREQ];
   logic [DW-1:0]   rq_data [NREQ];

   // reference model state
   int              m_ptr;
   logic            m_wena;
   logic [AW-1:0]   m_waddr;
   logic [DW-1:0]   m_wdata;
   logic [NREGS-1:0] m_busy;
   int              last_g;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      req_vld = rq_vld;
      for (int k = 0; k < NREQ; k++) begin
         req_addr[k*AW +: AW] = rq_addr[k];
         req_data[k*DW +: DW] = rq_data[k];
      end
   endtask

   // One clock: check grant, advance model at the edge, check registered outputs.
   task automatic tick();
      int              g;
      logic [AW-1:0]   wa;
      logic [DW-1:0]   wd;
      logic [NREQ-1:0] exp_rdy;
      logic            s_rst, s_iss, s_flush;
      logic [AW-1:0]   s_ia;
      drive();
      #1;
      g = -1;
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (g < 0 && rq_vld[k]) g = k;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("rdy", req_rdy, exp_rdy);
      wa = '0;
      wd = '0;
      if (g >= 0) begin
         wa = rq_addr[g];
         wd = rq_data[g];
      end
      s_rst = rst; s_iss = issue_vld; s_ia = issue_addr; s_flush = flush;
      @(posedge clk);
      if (s_rst) begin
         m_ptr = 0; m_wena = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
      end else begin
         if (g >= 0) begin
            m_waddr = wa;
            m_wdata = wd;
            m_wena  = (wa != 0);
            m_ptr   = (g + 1) % NREQ;
         end else begin
            m_wena = 0;
         end
         if (s_flush) begin
            m_busy = '0;
         end else begin
            for (int r = 1; r < NREGS; r++) begin
               if (s_iss && s_ia == AW'(r)) m_busy[r] = 1'b1;
               else if (g >= 0 && wa == AW'(r)) m_busy[r] = 1'b0;
            end
         end
      end
      last_g = g;
      #1;
      chk("wena", reg_wena, m_wena);
      chk("waddr", reg_waddr, m_waddr);
      chk("wdata", reg_wdata, m_wdata);
      chk("busy", busy, m_busy);
   endtask

   initial begin
      m_ptr = 0; m_wena = 0; m_waddr = '0; m_wdata = '0; m_busy = '0; last_g = -1;
      issue_vld = 0; issue_addr = '0; flush = 0;

      // reset held with all requesters valid
      rst = 1;
      rq_vld = 3'b111;
      for (int k = 0; k < NREQ; k++) begin
         rq_addr[k] = AW'(k + 1);
         rq_data[k] = 32'hA0 + DW'(k);
      end
      tick();
      tick();
      chk("reset_wena", reg_wena, 1'b0);
      chk("reset_busy", busy, 32'h0);

      // all valid: rotation 0,1,2,0 with one-cycle write latency
      rst = 0;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("grant_seq", last_g, n % 3);
         chk("waddr_seq", reg_waddr, (n % 3) + 1);
         chk("wena_seq", reg_wena, 1'b1);
      end

      // ptr=1 with only requester 0 valid: granted immediately
      rq_vld = 3'b001;
      tick();
      chk("wrap_grant", last_g, 0);
      rq_vld = 3'b111;
      tick();
      chk("ptr_after_wrap", last_g, 1);

      // write to x0: accepted, suppressed
      rq_vld = 3'b001;
      rq_addr[0] = '0;
      rq_data[0] = 32'hFFFF_FFFF;
      tick();
      chk("x0_grant", last_g, 0);
      chk("x0_wena", reg_wena, 1'b0);
      rq_vld = 3'b111;
      rq_addr[0] = 5'd1;
      tick();
      chk("x0_ptr", last_g, 1);

      // scoreboard set / clear / set-beats-clear
      rq_vld = 3'b000;
      issue_vld = 1; issue_addr = 5'd5;
      tick();
      chk("busy5_set", busy[5], 1'b1);
      issue_vld = 0;
      tick();
      tick();
      rq_vld = 3'b100; rq_addr[2] = 5'd5; rq_data[2] = 32'h5555;
      tick();
      chk("busy5_clr_grant", last_g, 2);
      chk("busy5_clr", busy[5], 1'b0);
      rq_vld = 3'b001; rq_addr[0] = 5'd5;
      issue_vld = 1; issue_addr = 5'd5;
      tick();
      chk("busy5_set_wins", busy[5], 1'b1);
      issue_vld = 0;
      rq_vld = 3'b010; rq_addr[1] = 5'd5;
      tick();

      // flush with concurrent issue and grant
      rq_vld = 3'b000;
      issue_vld = 1;
      for (int r = 4; r < 8; r++) begin
         issue_addr = AW'(r);
         tick();
      end
      issue_vld = 0;
      chk("busy_f0", busy, 32'h0000_00F0);
      flush = 1; issue_vld = 1; issue_addr = 5'd7;
      rq_vld = 3'b010; rq_addr[1] = 5'd9; rq_data[1] = 32'h1234_5678;
      tick();
      chk("flush_busy", busy, 32'h0);
      chk("flush_wena", reg_wena, 1'b1);
      chk("flush_waddr", reg_waddr, 5'd9);
      flush = 0; issue_vld = 0;
      rq_vld = 3'b000;

      // randomized traffic; requests hold until accepted
      for (int c = 0; c < 400; c++) begin
         rst        = ($urandom_range(0, 49) == 0);
         flush      = ($urandom_range(0, 19) == 0);
         issue_vld  = $urandom_range(0, 1);
         issue_addr = AW'($urandom_range(0, NREGS - 1));
         for (int k = 0; k < NREQ; k++) begin
            if (!rq_vld[k] && $urandom_range(0, 1) == 1) begin
               rq_vld[k]  = 1'b1;
               rq_addr[k] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, NREGS - 1));
               rq_data[k] = $urandom;
            end
         end
         tick();
         if (last_g >= 0) rq_vld[last_g] = 1'b0;
      end
      rst = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
